sin_gen_ctrl: RTL and testbench

//   Sequencer for the sin_gen sample source feeding the DSM DAC path.

---
 rtl/sin_gen_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sin_gen_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sin_gen_ctrl.sv
// Sequencer for sin_gen: divides core clock into the sample strobe, runs N-period bursts or free-runs.
// All outputs are registered; sample_valid trails clk_en by GEN_LATENCY cycles.
module sin_gen_ctrl #(
  parameter int DIV_WIDTH    = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int PTS_PER_WAVE = 50,
  parameter int GEN_LATENCY  = 1,
  localparam int IDX_W       = (PTS_PER_WAVE > 1) ? $clog2(PTS_PER_WAVE) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CNT_WIDTH-1:0] n_waves,
  output logic                 clk_en,
  output logic                 sample_valid,
  output logic [IDX_W-1:0]     sample_idx,
  output logic [CNT_WIDTH-1:0] wave_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 cfg_err
);

  localparam int DRN_W = (GEN_LATENCY > 1) ? $clog2(GEN_LATENCY) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PTS_PER_WAVE - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(GEN_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [CNT_WIDTH-1:0]   n_waves_q;
  logic                   cont_q;
  logic                   first_q;
  logic [DRN_W-1:0]       drain_cnt;
  logic [GEN_LATENCY-1:0] sv_sr;

  logic                   cfg_ok;
  logic                   accept;
  logic                   div_hit;
  logic                   strobe;
  logic                   wave_done;
  logic [IDX_W-1:0]       idx_nxt;

  assign cfg_ok    = (div != '0) && (continuous || (n_waves != '0));
  assign accept    = (state == IDLE) && start && !stop && cfg_ok;
  assign div_hit   = (div_cnt == div_q - DIV_WIDTH'(1));
  assign idx_nxt   = (first_q || (sample_idx == IDX_LAST)) ? '0 : sample_idx + IDX_W'(1);
  // A period counts as complete on the strobe that lands on its last sample.
  assign wave_done = (idx_nxt == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    strobe    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (div_hit) begin
          strobe = 1'b1;
          if (!cont_q && wave_done && (wave_cnt + CNT_WIDTH'(1) == n_waves_q)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRN_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q      <= '0;
      n_waves_q  <= '0;
      cont_q     <= 1'b0;
      div_cnt    <= '0;
      first_q    <= 1'b0;
      sample_idx <= '0;
      wave_cnt   <= '0;
      aborted    <= 1'b0;
      drain_cnt  <= '0;
      clk_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      clk_en  <= strobe;
      busy    <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done    <= (state_nxt == DONE);
      cfg_err <= (state == IDLE) && start && !stop && !cfg_ok;

      if (accept) begin
        div_q      <= div;
        n_waves_q  <= n_waves;
        cont_q     <= continuous;
        div_cnt    <= '0;
        first_q    <= 1'b1;
        sample_idx <= '0;
        wave_cnt   <= '0;
        aborted    <= 1'b0;
      end

      if (state == RUN) begin
        div_cnt <= div_hit ? '0 : div_cnt + DIV_WIDTH'(1);
        if (stop) begin
          aborted <= 1'b1;
        end
      end

      if (strobe) begin
        first_q    <= 1'b0;
        sample_idx <= idx_nxt;
        if (wave_done) begin
          wave_cnt <= wave_cnt + CNT_WIDTH'(1);
        end
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + DRN_W'(1) : '0;
    end
  end

  // Delay line matching the generator's clk_en-to-output latency.
  if (GEN_LATENCY == 1) begin : g_sv_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sv_sr <= '0;
      end else begin
        sv_sr <= clk_en;
      end
    end
  end else begin : g_sv_multi
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sv_sr <= '0;
      end else begin
        sv_sr <= {sv_sr[GEN_LATENCY-2:0], clk_en};
      end
    end
  end

  assign sample_valid = sv_sr[GEN_LATENCY-1];

endmodule

// File: tb/tb_sin_gen_ctrl.sv
// Randomized and directed bench for sin_gen_ctrl against an arithmetic strobe-timeline model.
module tb_sin_gen_ctrl;

  localparam int PTS = 50;
  localparam int GL  = 1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [15:0] div;
  logic [15:0] n_waves;
  logic        clk_en;
  logic        sample_valid;
  logic [5:0]  sample_idx;
  logic [15:0] wave_cnt;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  sin_gen_ctrl #(
    .DIV_WIDTH   (16),
    .CNT_WIDTH   (16),
    .PTS_PER_WAVE(PTS),
    .GEN_LATENCY (GL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .div         (div),
    .n_waves     (n_waves),
    .clk_en      (clk_en),
    .sample_valid(sample_valid),
    .sample_idx  (sample_idx),
    .wave_cnt    (wave_cnt),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cfg_err     (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_clk_en"}, 32'(clk_en), 0);
    chk({pfx, "_sample_valid"}, 32'(sample_valid), 0);
    chk({pfx, "_sample_idx"}, 32'(sample_idx), 0);
    chk({pfx, "_wave_cnt"}, 32'(wave_cnt), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_aborted"}, 32'(aborted), 0);
    chk({pfx, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  // Strobes issued on edges 1..tt after the start edge: every d-th edge,
  // capped by burst length and by the stop edge (a strobe at the stop edge is lost).
  function automatic int nstrobes(int tt, int d, int ntot, bit cont, int tstop);
    int k;
    if (tt <= 0) return 0;
    k = tt / d;
    if (!cont && k > ntot) k = ntot;
    if (tstop > 0 && (tstop - 1) / d < k) k = (tstop - 1) / d;
    return k;
  endfunction

  // Caller is just after a falling edge. tstop = edges after start at which stop is sampled (0 = none).
  task automatic run(input int d, input int n, input bit cont, input int tstop_in);
    int  ntot, tend, tstop, ks, ce_cnt, sv_cnt;
    bit  ce_exp, sv_exp;
    ntot  = n * PTS;
    tstop = tstop_in;
    if (cont && tstop == 0) tstop = 100;
    if (!cont && tstop > ntot * d) tstop = 0;
    tend   = (tstop > 0) ? tstop : ntot * d;
    ce_cnt = 0;
    sv_cnt = 0;

    div        = 16'(d);
    n_waves    = 16'(n);
    continuous = cont;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    div        = 16'($urandom);
    n_waves    = 16'($urandom);
    continuous = 1'($urandom);

    for (int t = 0; t <= tend + GL + 2; t++) begin
      ks     = nstrobes(t, d, ntot, cont, tstop);
      ce_exp = (ks != nstrobes(t - 1, d, ntot, cont, tstop));
      sv_exp = (nstrobes(t - GL, d, ntot, cont, tstop) != nstrobes(t - GL - 1, d, ntot, cont, tstop));
      chk($sformatf("clk_en@t%0d", t), 32'(clk_en), 32'(ce_exp));
      chk($sformatf("sample_valid@t%0d", t), 32'(sample_valid), 32'(sv_exp));
      chk($sformatf("sample_idx@t%0d", t), 32'(sample_idx), (ks == 0) ? 0 : 32'((ks - 1) % PTS));
      chk($sformatf("wave_cnt@t%0d", t), 32'(wave_cnt), 32'((ks / PTS) & 16'hFFFF));
      chk($sformatf("busy@t%0d", t), 32'(busy), 32'(t < tend + GL));
      chk($sformatf("done@t%0d", t), 32'(done), 32'(t == tend + GL));
      chk($sformatf("aborted@t%0d", t), 32'(aborted), 32'(tstop > 0 && t >= tstop));
      chk($sformatf("cfg_err@t%0d", t), 32'(cfg_err), 0);
      ce_cnt += int'(clk_en);
      sv_cnt += int'(sample_valid);
      // Stray start/stop while the run is in flight must be ignored.
      start = (t + 1 <= tend + GL) && ($urandom_range(0, 6) == 0);
      if (tstop > 0) stop = (t + 1 == tstop) || ((t + 1 > tstop) && (t + 1 <= tend + GL) && $urandom_range(0, 3) == 0);
      else           stop = (t + 1 > tend) && (t + 1 <= tend + GL) && ($urandom_range(0, 1) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("clk_en_total", 32'(ce_cnt), 32'(nstrobes(tend + GL + 2, d, ntot, cont, tstop)));
    chk("valid_vs_strobe_count", 32'(sv_cnt), 32'(ce_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d, n, ts;
    bit c;
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    continuous = 1'b0;
    div        = 16'd2;
    n_waves    = 16'd1;

    // Reset held with start toggling
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset");
      start = ~start;
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Burst, div=2, one period
    run(2, 1, 1'b0, 0);
    chk("burst_last_idx", 32'(sample_idx), 49);
    chk("burst_wave_cnt", 32'(wave_cnt), 1);
    chk("burst_aborted", 32'(aborted), 0);

    // Continuous, div=1, stop after 120 strobes
    run(1, 0, 1'b1, 121);
    chk("cont_idx", 32'(sample_idx), 19);
    chk("cont_wave_cnt", 32'(wave_cnt), 2);
    chk("cont_aborted", 32'(aborted), 1);

    // Illegal configs and start+stop collision
    div = 16'd0; n_waves = 16'd5; continuous = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_div0_err", 32'(cfg_err), 1);
    chk("cfg_div0_busy", 32'(busy), 0);
    @(negedge clk);
    chk("cfg_div0_pulse", 32'(cfg_err), 0);
    chk("cfg_div0_busy2", 32'(busy), 0);
    div = 16'd3; n_waves = 16'd0; continuous = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_nw0_err", 32'(cfg_err), 1);
    chk("cfg_nw0_busy", 32'(busy), 0);
    div = 16'd0; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_cont_div0_err", 32'(cfg_err), 1);
    div = 16'd2; n_waves = 16'd1; continuous = 1'b0; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", 32'(busy), 0);
    chk("start_stop_cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    chk("start_stop_busy2", 32'(busy), 0);
    chk("start_stop_clk_en", 32'(clk_en), 0);

    // Alignment with div=3
    run(3, 1, 1'b0, 0);

    // Async reset mid-burst, then a clean burst
    div = 16'd2; n_waves = 16'd1; continuous = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("ar_busy_before", 32'(busy), 1);
    chk("ar_idx_before", 32'(sample_idx), 9);
    #2 rst = 1'b0;
    #1 chk_all_zero("ar_immediate");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_done", 32'(done), 0);
      chk("ar_idle", 32'(busy), 0);
    end
    run(2, 1, 1'b0, 0);
    chk("ar_rerun_idx", 32'(sample_idx), 49);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      d  = $urandom_range(1, 4);
      n  = $urandom_range(1, 3);
      c  = 1'($urandom_range(0, 1));
      if (c)                             ts = $urandom_range(1, 200);
      else if ($urandom_range(0, 2) == 0) ts = $urandom_range(1, n * PTS * d);
      else                               ts = 0;
      run(d, n, c, ts);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
